// File: rtl/mem_wb_skid_reg_pkg.sv
// Shared definitions for the MEM->WB skid boundary: state encoding,
// default widths and small helpers used by the top and its checkers.
package mem_wb_skid_reg_pkg;

   // Default geometry of one pipeline boundary instance.
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_REG_ADDR_W = 5;
   localparam int DEF_CNT_W      = 16;

   // Number of held entries is encoded directly in the state value.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_e;

   // Width of one stored entry: regWrite + memToReg + writeReg + readData + ALUOut.
   function automatic int entry_w(input int data_w, input int reg_addr_w);
      return 2 + reg_addr_w + (2 * data_w);
   endfunction

   // Held-entry count for a given state; illegal encodings report zero.
   function automatic logic [1:0] occ_of(input state_e st);
      logic [1:0] occ;
      case (st)
         EMPTY:   occ = 2'd0;
         FULL:    occ = 2'd1;
         SKID:    occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/mem_wb_skid_reg_if.sv
// Bus bundle for the MEM->WB boundary: MEM-side handshake and entry fields,
// WB-side handshake and entry fields, flush and status.
interface mem_wb_skid_reg_if #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
);
   // MEM side
   logic                  flush;
   logic                  inValid;
   logic                  inReady;
   logic                  regWriteM;
   logic                  memToRegM;
   logic [REG_ADDR_W-1:0] writeRegM;
   logic [DATA_W-1:0]     readDataM;
   logic [DATA_W-1:0]     ALUOutM;
   // WB side
   logic                  outValid;
   logic                  outReady;
   logic                  regWriteW;
   logic                  wbEnW;
   logic                  memToRegW;
   logic [REG_ADDR_W-1:0] writeRegW;
   logic [DATA_W-1:0]     readDataW;
   logic [DATA_W-1:0]     ALUOutW;
   logic [DATA_W-1:0]     resultW;
   // Status
   logic [1:0]            occupancy;
   logic [CNT_W-1:0]      stallCount;

   // Environment view: drives MEM-side entries and the WB-side ready.
   modport master (
      output flush, inValid, regWriteM, memToRegM, writeRegM, readDataM, ALUOutM, outReady,
      input  inReady, outValid, regWriteW, wbEnW, memToRegW, writeRegW, readDataW,
             ALUOutW, resultW, occupancy, stallCount
   );

   // Boundary view: the register stage itself.
   modport slave (
      input  flush, inValid, regWriteM, memToRegM, writeRegM, readDataM, ALUOutM, outReady,
      output inReady, outValid, regWriteW, wbEnW, memToRegW, writeRegW, readDataW,
             ALUOutW, resultW, occupancy, stallCount
   );
endinterface

// File: rtl/mem_wb_skid_reg_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset. Sticks at the
// all-ones value once reached; only reset brings it back to zero.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: step by one unless already saturated.
   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_ONE;
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= {CNT_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/mem_wb_skid_reg.sv
// MEM->WB pipeline boundary with valid/ready handshake and a two-entry skid
// buffer. Upstream ready comes straight from the state register, so there is
// no combinational path from outReady back to inReady. The main entry drives
// the WB outputs; the skid entry only catches the one transfer that arrives
// while the WB stage is stalled.
module mem_wb_skid_reg
   import mem_wb_skid_reg_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   mem_wb_skid_reg_if.slave      bus
);

   localparam int ENTRY_W = entry_w(DATA_W, REG_ADDR_W);

   typedef struct packed {
      logic                  reg_write;
      logic                  mem_to_reg;
      logic [REG_ADDR_W-1:0] write_reg;
      logic [DATA_W-1:0]     read_data;
      logic [DATA_W-1:0]     alu_out;
   } entry_t;

   localparam entry_t ENTRY_ZERO = entry_t'({ENTRY_W{1'b0}});

   state_e state_q;
   state_e state_d;
   entry_t main_q;
   entry_t main_d;
   entry_t skid_q;
   entry_t skid_d;
   entry_t in_s;
   logic   accept_s;
   logic   in_ready_s;
   logic   out_valid_s;
   logic   stall_inc_s;

   assign in_s = '{
      reg_write:  bus.regWriteM,
      mem_to_reg: bus.memToRegM,
      write_reg:  bus.writeRegM,
      read_data:  bus.readDataM,
      alu_out:    bus.ALUOutM
   };

   assign in_ready_s  = (state_q != SKID);
   assign out_valid_s = (state_q != EMPTY);
   assign accept_s    = bus.inValid & in_ready_s;
   assign stall_inc_s = out_valid_s & ~bus.outReady;

   // Next state and entry movement; flush squashes everything including a
   // same-cycle accept. Data registers are left stale on flush.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (bus.flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept_s) begin
                  state_d = FULL;
                  main_d  = in_s;
               end else begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (accept_s && bus.outReady) begin
                  state_d = FULL;
                  main_d  = in_s;
               end else if (accept_s) begin
                  state_d = SKID;
                  skid_d  = in_s;
               end else if (bus.outReady) begin
                  state_d = EMPTY;
               end else begin
                  state_d = FULL;
               end
            end
            SKID: begin
               if (bus.outReady) begin
                  state_d = FULL;
                  main_d  = skid_q;
               end else begin
                  state_d = SKID;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

   // State and entry storage; reset clears data so every W output reads 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
         main_q  <= ENTRY_ZERO;
         skid_q  <= ENTRY_ZERO;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk     (clk),
      .rst     (reset),
      .inc_i   (stall_inc_s),
      .count_o (bus.stallCount)
   );

   assign bus.inReady   = in_ready_s;
   assign bus.outValid  = out_valid_s;
   assign bus.occupancy = occ_of(state_q);
   assign bus.regWriteW = main_q.reg_write & out_valid_s;
   assign bus.wbEnW     = main_q.reg_write & out_valid_s & bus.outReady;
   assign bus.memToRegW = main_q.mem_to_reg;
   assign bus.writeRegW = main_q.write_reg;
   assign bus.readDataW = main_q.read_data;
   assign bus.ALUOutW   = main_q.alu_out;
   assign bus.resultW   = main_q.mem_to_reg ? main_q.read_data : main_q.alu_out;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Self-checking bench for mem_wb_skid_reg: directed scenarios followed by
// random traffic, all compared against a FIFO-of-entries reference model.
module tb_mem_wb_skid_reg;

   localparam int DW = 32;
   localparam int RW = 5;
   localparam int CW = 3;
   localparam int SAT = 7;

   typedef struct {
      bit          rw;
      bit          m2r;
      bit [RW-1:0] wr;
      bit [DW-1:0] rd;
      bit [DW-1:0] alu;
   } ent_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   ent_t mq[$];
   int   stall_m;

   mem_wb_skid_reg_if #(.DATA_W(DW), .REG_ADDR_W(RW), .CNT_W(CW)) bus ();

   mem_wb_skid_reg #(.DATA_W(DW), .REG_ADDR_W(RW), .CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit [DW-1:0] res_of(input ent_t e);
      return e.m2r ? e.rd : e.alu;
   endfunction

   // Checks that depend on the current (pre-edge) inputs.
   task automatic check_pre();
      bit exp_wb;
      exp_wb = (mq.size() > 0) && mq[0].rw && bus.outReady;
      chk("inReady_pre", 64'(bus.inReady), 64'(mq.size() < 2));
      chk("wbEnW", 64'(bus.wbEnW), 64'(exp_wb));
   endtask

   // Checks of everything held in the boundary after an edge.
   task automatic check_post();
      chk("outValid", 64'(bus.outValid), 64'(mq.size() > 0));
      chk("inReady", 64'(bus.inReady), 64'(mq.size() < 2));
      chk("occupancy", 64'(bus.occupancy), 64'(mq.size()));
      chk("stallCount", 64'(bus.stallCount), 64'(stall_m));
      if (mq.size() > 0) begin
         chk("regWriteW", 64'(bus.regWriteW), 64'(mq[0].rw));
         chk("memToRegW", 64'(bus.memToRegW), 64'(mq[0].m2r));
         chk("writeRegW", 64'(bus.writeRegW), 64'(mq[0].wr));
         chk("readDataW", 64'(bus.readDataW), 64'(mq[0].rd));
         chk("ALUOutW", 64'(bus.ALUOutW), 64'(mq[0].alu));
         chk("resultW", 64'(bus.resultW), 64'(res_of(mq[0])));
      end else begin
         chk("regWriteW_idle", 64'(bus.regWriteW), 64'd0);
      end
   endtask

   // Reference behaviour at a rising edge: a two-deep FIFO of entries.
   task automatic model_edge();
      bit   acc;
      ent_t e;
      acc = bus.inValid && (mq.size() < 2);
      e.rw = bus.regWriteM; e.m2r = bus.memToRegM; e.wr = bus.writeRegM;
      e.rd = bus.readDataM; e.alu = bus.ALUOutM;
      if ((mq.size() > 0) && !bus.outReady && (stall_m < SAT)) stall_m++;
      if (bus.flush) begin
         mq.delete();
      end else begin
         if ((mq.size() > 0) && bus.outReady) void'(mq.pop_front());
         if (acc) mq.push_back(e);
      end
   endtask

   task automatic step(input bit iv, input bit rw, input bit m2r, input bit [RW-1:0] wr,
                       input bit [DW-1:0] rd, input bit [DW-1:0] alu,
                       input bit ordy, input bit fl);
      @(negedge clk);
      bus.inValid = iv; bus.regWriteM = rw; bus.memToRegM = m2r; bus.writeRegM = wr;
      bus.readDataM = rd; bus.ALUOutM = alu; bus.outReady = ordy; bus.flush = fl;
      #1;
      check_pre();
      @(posedge clk);
      model_edge();
      #1;
      check_post();
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      mq.delete();
      stall_m = 0;
      chk("rst_outValid", 64'(bus.outValid), 64'd0);
      chk("rst_inReady", 64'(bus.inReady), 64'd1);
      chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
      chk("rst_stallCount", 64'(bus.stallCount), 64'd0);
      chk("rst_regWriteW", 64'(bus.regWriteW), 64'd0);
      chk("rst_wbEnW", 64'(bus.wbEnW), 64'd0);
      chk("rst_memToRegW", 64'(bus.memToRegW), 64'd0);
      chk("rst_writeRegW", 64'(bus.writeRegW), 64'd0);
      chk("rst_readDataW", 64'(bus.readDataW), 64'd0);
      chk("rst_ALUOutW", 64'(bus.ALUOutW), 64'd0);
      chk("rst_resultW", 64'(bus.resultW), 64'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0; stall_m = 0;
      reset = 1'b0;
      bus.inValid = 1'b0; bus.regWriteM = 1'b0; bus.memToRegM = 1'b0; bus.writeRegM = 5'd0;
      bus.readDataM = 32'd0; bus.ALUOutM = 32'd0; bus.outReady = 1'b0; bus.flush = 1'b0;
      do_reset();

      // Reset in the middle of SKID: two entries held, WB stalled.
      step(1'b1, 1'b1, 1'b0, 5'd3, 32'h1111_2222, 32'h3333_4444, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 5'd9, 32'h5555_6666, 32'h7777_8888, 1'b0, 1'b0);
      chk("skid_occ_before_reset", 64'(bus.occupancy), 64'd2);
      step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      do_reset();

      // Streaming at full rate, one result per cycle.
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, 1'b1, 1'b0, 5'd7, 32'hDEAD_0000, 32'(i), 1'b1, 1'b0);
         chk("stream_result", 64'(bus.resultW), 64'(i));
      end
      step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);

      // Backpressure: A then B held, third offer refused, then drained in order.
      step(1'b1, 1'b1, 1'b1, 5'd1, 32'hAAAA_0000, 32'h0000_0A0A, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 5'd2, 32'hBBBB_0000, 32'h0000_0B0B, 1'b0, 1'b0);
      chk("bp_inReady_low", 64'(bus.inReady), 64'd0);
      step(1'b1, 1'b1, 1'b0, 5'd3, 32'hCCCC_0000, 32'h0000_0C0C, 1'b0, 1'b0);
      chk("bp_occ_held", 64'(bus.occupancy), 64'd2);
      chk("bp_A", 64'(bus.resultW), 64'h0000_0000_AAAA_0000);
      step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      chk("bp_B", 64'(bus.resultW), 64'h0000_0000_BBBB_0000);
      step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);

      // Write-enable qualification: stalled write then release.
      step(1'b1, 1'b1, 1'b0, 5'd12, 32'd0, 32'h0000_1234, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);

      // Flush with a concurrent accept while FULL.
      step(1'b1, 1'b1, 1'b0, 5'd4, 32'd0, 32'h0000_0044, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 5'd5, 32'd0, 32'h0000_0055, 1'b0, 1'b1);
      chk("flush_outValid", 64'(bus.outValid), 64'd0);
      chk("flush_wbEnW", 64'(bus.wbEnW), 64'd0);
      step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);

      // Stall counter saturation; flush leaves it alone, reset clears it.
      do_reset();
      step(1'b1, 1'b1, 1'b0, 5'd6, 32'd0, 32'h0000_0066, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      end
      chk("stall_saturated", 64'(bus.stallCount), 64'd7);
      step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      chk("stall_after_flush", 64'(bus.stallCount), 64'd7);
      do_reset();

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom), 1'($urandom), 1'($urandom), RW'($urandom), $urandom, $urandom,
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      end
      do_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
